itf_periodic_timer: RTL and testbench

//   Downstream consumer of the t_itf register bank. Takes the software-written areg word
//   (enable + period) and produces a periodic single-cycle tick to the fabric.

---
 rtl/itf_timer_pkg.sv | 19 +
 rtl/itf_periodic_timer_if.sv | 13 +
 rtl/itf_timer_prescaler.sv | 35 +++
 rtl/itf_periodic_timer.sv | 92 +++++++++
 tb/tb_itf_periodic_timer.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/itf_timer_pkg.sv
// Shared types and areg field positions for the periodic timer.
package itf_timer_pkg;

  typedef enum logic [0:0] {
    IDLE,
    RUN
  } t_tmr_state;

  localparam int unsigned AREG_W     = 32;
  localparam int unsigned EN_BIT     = 31;
  localparam int unsigned PERIOD_MSB = 30;
  localparam int unsigned PERIOD_LSB = 0;
  localparam int unsigned PERIOD_W   = PERIOD_MSB - PERIOD_LSB + 1;

  function automatic int unsigned pc_width(input int unsigned prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/itf_periodic_timer_if.sv
// Register-bank side of the timer: areg word in, status fields and tick out.
interface itf_periodic_timer_if;
  import itf_timer_pkg::*;

  logic [AREG_W-1:0] areg;
  logic              regf_f0;
  logic              regf_f1;
  logic              tick;

  modport master (output areg, input regf_f0, input regf_f1, input tick);
  modport slave  (input areg, output regf_f0, output regf_f1, output tick);

endinterface

// File: rtl/itf_timer_prescaler.sv
// Free-running divider; strobe_o marks the last cycle of each PRESCALE-cycle slot.
module itf_timer_prescaler
  import itf_timer_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  output logic strobe_o
);

  localparam int unsigned PcW = pc_width(PRESCALE);
  localparam logic [PcW-1:0] PcMax = PcW'(PRESCALE - 1);

  logic [PcW-1:0] pc_q, pc_d;

  assign strobe_o = (pc_q == PcMax);

  always_comb begin
    pc_d = pc_q + 1'b1;
    if (clr_i || strobe_o) begin
      pc_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/itf_periodic_timer.sv
// Periodic tick generator driven by the areg word (enable + period in prescaled ticks).
module itf_periodic_timer
  import itf_timer_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  itf_periodic_timer_if.slave  bus
);

  logic                en;
  logic [PERIOD_W-1:0] period;
  logic                go;
  logic                strobe;
  logic                clr;

  t_tmr_state          state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                f0_q;
  logic                f1_q, f1_d;
  logic                tick_q, tick_d;

  assign en     = bus.areg[EN_BIT];
  assign period = bus.areg[PERIOD_MSB:PERIOD_LSB];
  assign go     = en && (period != '0);

  // Hold the divider at zero outside RUN and on the exit edge so re-entry starts a full slot.
  assign clr = (state_q != RUN) || (state_d != RUN);

  itf_timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .clr_i    (clr),
    .strobe_o (strobe)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f1_d    = f1_q;
    tick_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (go) begin
          state_d = RUN;
          cnt_d   = period - PERIOD_W'(1);
        end
      end
      RUN: begin
        if (!go) begin
          // Exit takes priority over a tick due on the same edge.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (strobe) begin
          if (cnt_q == '0) begin
            tick_d = 1'b1;
            f1_d   = ~f1_q;
            cnt_d  = period - PERIOD_W'(1);
          end else begin
            cnt_d = cnt_q - PERIOD_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      f0_q    <= 1'b0;
      f1_q    <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f0_q    <= (state_d == RUN);
      f1_q    <= f1_d;
      tick_q  <= tick_d;
    end
  end

  assign bus.regf_f0 = f0_q;
  assign bus.regf_f1 = f1_q;
  assign bus.tick    = tick_q;

endmodule

// File: tb/tb_itf_periodic_timer.sv
// Scoreboarded bench: two timers (PRESCALE 1 and 3), expected tick cycles queued by stimulus.
module tb_itf_periodic_timer;

  typedef struct {
    int   cyc;
    logic f1;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t q1[$];
  exp_t q3[$];
  logic f1m1 = 1'b0;
  logic f1m3 = 1'b0;

  itf_periodic_timer_if bus1 ();
  itf_periodic_timer_if bus3 ();

  itf_periodic_timer #(.PRESCALE(1)) dut1 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus1));
  itf_periodic_timer #(.PRESCALE(3)) dut3 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus3));

  always #5 clk = ~clk;

  // After rising edge number k, cyc == k; a tick produced by edge k is visible while cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Queue n ticks at e+period, e+2*period, ... with the toggled f1 value each tick should show.
  task automatic expect_ticks(input bit sel, input int e, input int period, input int n);
    for (int k = 1; k <= n; k++) begin
      if (sel) begin
        f1m3 = ~f1m3;
        q3.push_back('{cyc: e + k * period, f1: f1m3});
      end else begin
        f1m1 = ~f1m1;
        q1.push_back('{cyc: e + k * period, f1: f1m1});
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (q1.size() > 0 && q1[0].cyc < cyc) begin
        e = q1.pop_front();
        check("dut1_tick_missing", cyc, e.cyc);
      end
      if (bus1.tick) begin
        if (q1.size() == 0) check("dut1_tick_unexpected", cyc, -1);
        else begin
          e = q1.pop_front();
          check("dut1_tick_cycle", cyc, e.cyc);
          check("dut1_tick_f1", int'(bus1.regf_f1), int'(e.f1));
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (q3.size() > 0 && q3[0].cyc < cyc) begin
        e = q3.pop_front();
        check("dut3_tick_missing", cyc, e.cyc);
      end
      if (bus3.tick) begin
        if (q3.size() == 0) check("dut3_tick_unexpected", cyc, -1);
        else begin
          e = q3.pop_front();
          check("dut3_tick_cycle", cyc, e.cyc);
          check("dut3_tick_f1", int'(bus3.regf_f1), int'(e.f1));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int e;
    bus1.areg = '0;
    bus3.areg = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_f0_1", int'(bus1.regf_f0), 0);
    check("rst_f1_1", int'(bus1.regf_f1), 0);
    check("rst_tick_1", int'(bus1.tick), 0);
    check("rst_f0_3", int'(bus3.regf_f0), 0);
    check("rst_f1_3", int'(bus3.regf_f1), 0);
    check("rst_tick_3", int'(bus3.tick), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // PRESCALE=1, P=4: ticks every 4 cycles; clear enable the cycle before the fourth.
    @(negedge clk);
    bus1.areg = 32'h8000_0004;
    e = cyc + 1;
    expect_ticks(0, e, 4, 3);
    wait_cyc(e);
    check("p4_f0_on", int'(bus1.regf_f0), 1);
    wait_cyc(e + 15);
    bus1.areg = 32'h0000_0004;
    wait_cyc(e + 16);
    check("exit_f0_1", int'(bus1.regf_f0), 0);
    check("exit_f1_held_1", int'(bus1.regf_f1), 1);
    check("exit_no_tick_1", int'(bus1.tick), 0);

    // Re-enable: full period again, then exit right after the tick.
    wait_cyc(e + 18);
    bus1.areg = 32'h8000_0004;
    e = cyc + 1;
    expect_ticks(0, e, 4, 1);
    wait_cyc(e + 4);
    bus1.areg = 32'h0;

    // P=1: tick every cycle, f1 alternating; exit suppresses the next one.
    wait_cyc(e + 6);
    bus1.areg = 32'h8000_0001;
    e = cyc + 1;
    expect_ticks(0, e, 1, 6);
    wait_cyc(e + 6);
    bus1.areg = 32'h0;
    wait_cyc(e + 7);
    check("p1_exit_f0", int'(bus1.regf_f0), 0);
    check("p1_exit_f1", int'(bus1.regf_f1), int'(f1m1));

    // Enable with P=0 stays idle; then P=3 starts normally.
    bus1.areg = 32'h8000_0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("p0_f0_idle", int'(bus1.regf_f0), 0);
    end
    bus1.areg = 32'h8000_0003;
    e = cyc + 1;
    expect_ticks(0, e, 3, 2);
    wait_cyc(e);
    check("p3_f0_on", int'(bus1.regf_f0), 1);
    wait_cyc(e + 6);
    bus1.areg = 32'h0;
    wait_cyc(e + 8);
    check("q1_drained", q1.size(), 0);

    // PRESCALE=3, P=2: first tick at 6; P->5 mid-period ends that period at 6, next at 15.
    @(negedge clk);
    bus3.areg = 32'h8000_0002;
    e = cyc + 1;
    expect_ticks(1, e, 6, 1);
    wait_cyc(e);
    check("ps3_f0_on", int'(bus3.regf_f0), 1);
    wait_cyc(e + 8);
    bus3.areg = 32'h8000_0005;
    expect_ticks(1, e + 6, 6, 1);
    expect_ticks(1, e + 12, 15, 1);
    wait_cyc(e + 41);
    bus3.areg = 32'h0000_0005;
    wait_cyc(e + 42);
    check("ps3_exit_f0", int'(bus3.regf_f0), 0);
    check("ps3_exit_f1", int'(bus3.regf_f1), 1);
    check("ps3_exit_tick", int'(bus3.tick), 0);
    wait_cyc(e + 44);
    bus3.areg = 32'h8000_0002;
    e = cyc + 1;
    expect_ticks(1, e, 6, 1);
    wait_cyc(e + 7);

    // Both running, then asynchronous reset between clock edges.
    bus1.areg = 32'h8000_0001;
    begin
      int e1;
      e1 = cyc + 1;
      expect_ticks(0, e1, 1, 3);
      wait_cyc(e1 + 3);
    end
    check("pre_rst_tick_1", int'(bus1.tick), 1);
    check("pre_rst_f0_3", int'(bus3.regf_f0), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_f0_1", int'(bus1.regf_f0), 0);
    check("arst_f1_1", int'(bus1.regf_f1), 0);
    check("arst_tick_1", int'(bus1.tick), 0);
    check("arst_f0_3", int'(bus3.regf_f0), 0);
    check("arst_f1_3", int'(bus3.regf_f1), 0);
    check("arst_tick_3", int'(bus3.tick), 0);
    check("q1_final", q1.size(), 0);
    check("q3_final", q3.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
